// File: rtl/cim_pkg.sv
// cim_pkg: derived CIM datapath constants and the accumulator FSM state shared by sibling CIM blocks.
package cim_pkg;
    typedef enum logic [1:0] {ACC, FLUSH, DRAIN} cim_state_e;

    function automatic int clog2w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic int adc_precision(input int bit_cell, input int bit_dac, input int ouy);
        return bit_cell + bit_dac + $clog2(ouy) - ((bit_cell == 1 || bit_dac == 1) ? 1 : 0);
    endfunction

    localparam int BIT_CELL      = 2;
    localparam int BIT_DAC       = 1;
    localparam int BIT_W         = 8;
    localparam int BIT_IFM       = 8;
    localparam int OUY           = 32;
    localparam int W_SLICES      = BIT_W / BIT_CELL;
    localparam int X_SLICES      = BIT_IFM / BIT_DAC;
    localparam int ADC_PRECISION = adc_precision(BIT_CELL, BIT_DAC, OUY);
endpackage

// File: rtl/cim_slice_shifter.sv
// cim_slice_shifter: places an ADC count at its weight/input bit position and negates two's-complement MSB slices.
module cim_slice_shifter #(
    parameter int BIT_CELL = 2,
    parameter int BIT_DAC  = 1,
    parameter int W_SLICES = 4,
    parameter int X_SLICES = 8,
    parameter int ADC_W    = 7,
    parameter int BIT_ACC  = 32,
    parameter int WSW      = 2,
    parameter int XSW      = 3
) (
    input  logic [ADC_W-1:0]   adc_i,
    input  logic [WSW-1:0]     w_slice_i,
    input  logic [XSW-1:0]     x_slice_i,
    input  logic               signed_w_i,
    input  logic               signed_x_i,
    output logic [BIT_ACC-1:0] term_o
);
    logic [BIT_ACC-1:0] mag;
    logic               in_range;
    logic               neg;

    assign in_range = (32'(w_slice_i) < W_SLICES) && (32'(x_slice_i) < X_SLICES);
    // MSB slice of a two's-complement operand carries negative weight; two negatives cancel
    assign neg      = (signed_w_i && 32'(w_slice_i) == W_SLICES - 1) ^ (signed_x_i && 32'(x_slice_i) == X_SLICES - 1);
    assign mag      = BIT_ACC'(adc_i) << (32'(w_slice_i) * BIT_CELL + 32'(x_slice_i) * BIT_DAC);
    assign term_o   = !in_range ? '0 : neg ? -mag : mag;
endmodule

// File: rtl/cim_psum_accumulator.sv
// cim_psum_accumulator: accumulates shifted ADC slices into per-filter partial sums and drains them on the last beat.
module cim_psum_accumulator
    import cim_pkg::*;
#(
    parameter int BIT_CELL   = 2,
    parameter int BIT_DAC    = 1,
    parameter int BIT_W      = 8,
    parameter int OUY        = 32,
    parameter int BIT_IFM    = 8,
    parameter int NUM_FILTER = 32,
    parameter int BIT_ACC    = 32,
    localparam int W_SL      = BIT_W / BIT_CELL,
    localparam int X_SL      = BIT_IFM / BIT_DAC,
    localparam int ADC_W     = adc_precision(BIT_CELL, BIT_DAC, OUY),
    localparam int FW        = clog2w(NUM_FILTER),
    localparam int WSW       = clog2w(W_SL),
    localparam int XSW       = clog2w(X_SL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_signed_w,
    input  logic               cfg_signed_ifm,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADC_W-1:0]   adc_result,
    input  logic [FW-1:0]      filter_idx,
    input  logic [WSW-1:0]     w_slice,
    input  logic [XSW-1:0]     x_slice,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FW-1:0]      out_filter_idx,
    output logic [BIT_ACC-1:0] out_data,
    output logic               out_last
);
    cim_state_e         state_q, state_d;
    logic [FW-1:0]      ptr_q, ptr_d;
    logic               v_q;
    logic [FW-1:0]      fidx_q;
    logic [BIT_ACC-1:0] term_q;
    logic [BIT_ACC-1:0] term;
    logic [BIT_ACC-1:0] acc_q [NUM_FILTER];
    logic               accept;

    cim_slice_shifter #(
        .BIT_CELL(BIT_CELL), .BIT_DAC(BIT_DAC), .W_SLICES(W_SL), .X_SLICES(X_SL),
        .ADC_W(ADC_W), .BIT_ACC(BIT_ACC), .WSW(WSW), .XSW(XSW)
    ) u_shift (
        .adc_i      (adc_result),
        .w_slice_i  (w_slice),
        .x_slice_i  (x_slice),
        .signed_w_i (cfg_signed_w),
        .signed_x_i (cfg_signed_ifm),
        .term_o     (term)
    );

    assign in_ready       = state_q == ACC;
    assign accept         = in_valid && in_ready;
    assign out_valid      = state_q == DRAIN;
    assign out_filter_idx = out_valid ? ptr_q : '0;
    assign out_data       = out_valid ? acc_q[ptr_q] : '0;
    assign out_last       = out_valid && ptr_q == FW'(NUM_FILTER - 1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ACC:     state_d = (accept && in_last) ? FLUSH : ACC;
            FLUSH:   begin
                state_d = DRAIN;
                ptr_d   = '0;
            end
            DRAIN:   begin
                ptr_d   = out_ready ? ptr_q + 1'b1 : ptr_q;
                state_d = (out_ready && out_last) ? ACC : DRAIN;
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
            ptr_q   <= '0;
            v_q     <= 1'b0;
            fidx_q  <= '0;
            term_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            v_q     <= accept;
            fidx_q  <= filter_idx;
            term_q  <= term;
        end
    end

    // FLUSH separates the last stage-2 write from the first drain clear, so they never collide
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FILTER; i++) acc_q[i] <= '0;
        end else begin
            if (v_q) acc_q[fidx_q] <= acc_q[fidx_q] + term_q;
            if (out_valid && out_ready) acc_q[ptr_q] <= '0;
        end
    end
endmodule

// File: tb/tb_cim_psum_accumulator.sv
// tb_cim_psum_accumulator: directed scoreboard bench for the partial-sum accumulator, plus an 8-bit wrap instance.
module tb_cim_psum_accumulator;
    localparam int NF = 32;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_signed_w = 1'b0, cfg_signed_ifm = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, out_last;
    logic [6:0]  adc_result = '0;
    logic [4:0]  filter_idx = '0;
    logic [1:0]  w_slice = '0;
    logic [2:0]  x_slice = '0;
    logic [4:0]  out_filter_idx;
    logic [31:0] out_data;

    logic        in_valid2 = 1'b0, in_last2 = 1'b0, out_ready2 = 1'b0;
    logic        in_ready2, out_valid2, out_last2;
    logic [6:0]  adc2 = '0;
    logic [4:0]  out_idx2;
    logic [7:0]  out_data2;

    exp_t        sbq[$];
    logic [31:0] model [NF];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    cim_psum_accumulator dut (
        .clk(clk), .rst(rst), .cfg_signed_w(cfg_signed_w), .cfg_signed_ifm(cfg_signed_ifm),
        .in_valid(in_valid), .in_ready(in_ready), .adc_result(adc_result), .filter_idx(filter_idx),
        .w_slice(w_slice), .x_slice(x_slice), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_filter_idx(out_filter_idx), .out_data(out_data), .out_last(out_last)
    );

    cim_psum_accumulator #(.BIT_ACC(8)) dut_wrap (
        .clk(clk), .rst(rst), .cfg_signed_w(1'b0), .cfg_signed_ifm(1'b0),
        .in_valid(in_valid2), .in_ready(in_ready2), .adc_result(adc2), .filter_idx(5'd0),
        .w_slice(2'd0), .x_slice(3'd0), .in_last(in_last2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_filter_idx(out_idx2), .out_data(out_data2), .out_last(out_last2)
    );

    function automatic logic [31:0] mterm(input int adc, input int w, input int x, input logic sw, input logic sx);
        logic [31:0] t;
        t = 32'(adc) << (w * 2 + x);
        return ((sw && w == 3) != (sx && x == 7)) ? -t : t;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        for (int f = 0; f < NF; f++) model[f] = '0;
    endtask

    task automatic send(input int adc, input int f, input int w, input int x, input logic last);
        adc_result = 7'(adc);
        filter_idx = 5'(f);
        w_slice    = 2'(w);
        x_slice    = 3'(x);
        in_last    = last;
        in_valid   = 1'b1;
        chk("in_ready_at_send", 64'(in_ready), 64'd1);
        model[f] += mterm(adc, w, x, cfg_signed_w, cfg_signed_ifm);
        if (last) begin
            for (int k = 0; k < NF; k++) sbq.push_back('{idx: 5'(k), data: model[k], last: k == NF - 1});
            clear_model();
        end
        @(negedge clk);
        if (last) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_drain();
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("drain_start_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic drain(input int stall_at, input int stop_at);
        exp_t e;
        for (int i = 0; i < stop_at; i++) begin
            e = sbq.pop_front();
            if (i == stall_at) begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_valid", 64'(out_valid), 64'd1);
                    chk("stall_idx", 64'(out_filter_idx), 64'(e.idx));
                    chk("stall_data", 64'(out_data), 64'(e.data));
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                end
            end
            chk("drain_valid", 64'(out_valid), 64'd1);
            chk("drain_idx", 64'(out_filter_idx), 64'(e.idx));
            chk("drain_data", 64'(out_data), 64'(e.data));
            chk("drain_last", 64'(out_last), 64'(e.last));
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        if (stop_at == NF) begin
            chk("in_ready_after_drain", 64'(in_ready), 64'd1);
            chk("valid_after_drain", 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        clear_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_idx", 64'(out_filter_idx), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);

        send(5, 3, 1, 2, 1'b1);
        wait_drain();
        drain(-1, NF);

        cfg_signed_w = 1'b1;
        send(1, 0, 3, 0, 1'b1);
        wait_drain();
        drain(-1, NF);
        cfg_signed_ifm = 1'b1;
        send(1, 1, 3, 7, 1'b1);
        wait_drain();
        drain(-1, NF);
        cfg_signed_w   = 1'b0;
        cfg_signed_ifm = 1'b0;

        send(10, 7, 0, 0, 1'b0);
        send(20, 7, 0, 0, 1'b1);
        wait_drain();
        drain(-1, NF);

        send(3, 5, 0, 0, 1'b0);
        send(9, 6, 1, 1, 1'b1);
        wait_drain();
        drain(5, NF);

        send(2, 10, 0, 0, 1'b0);
        send(4, 12, 2, 0, 1'b1);
        wait_drain();
        drain(-1, 10);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data", 64'(out_data), 64'd0);
        chk("midrst_out_idx", 64'(out_filter_idx), 64'd0);
        chk("midrst_out_last", 64'(out_last), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        sbq.delete();
        clear_model();
        send(1, 12, 0, 0, 1'b1);
        wait_drain();
        drain(-1, NF);

        in_valid2 = 1'b1;
        adc2      = 7'd100;
        @(negedge clk);
        in_last2  = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        in_last2  = 1'b0;
        chk("wrap_flush_valid", 64'(out_valid2), 64'd0);
        @(negedge clk);
        chk("wrap_valid", 64'(out_valid2), 64'd1);
        chk("wrap_idx", 64'(out_idx2), 64'd0);
        chk("wrap_data", 64'(out_data2), 64'hC8);
        out_ready2 = 1'b1;
        repeat (NF) @(negedge clk);
        out_ready2 = 1'b0;
        chk("wrap_in_ready", 64'(in_ready2), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
